// File: rtl/aes_wddl_unload.sv
// Output end of the WDDL AES datapath: captures the final dual-rail state, checks the rails and streams true-rail bytes.
// Optional macro AES_WDDL_UNLOAD_PRECHARGE_EN adds out_data_n and a post-block precharge cycle.
module aes_wddl_unload #(
  parameter int NBYTES = 16,
  parameter int BYTE_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     done,
  input  logic [NBYTES*BYTE_W-1:0] sa_p,
  input  logic [NBYTES*BYTE_W-1:0] sa_n,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BYTE_W-1:0]        out_data,
`ifdef AES_WDDL_UNLOAD_PRECHARGE_EN
  output logic [BYTE_W-1:0]        out_data_n,
`endif
  output logic                     out_last,
  output logic                     busy,
  output logic                     err
);

  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
`ifdef AES_WDDL_UNLOAD_PRECHARGE_EN
    PRECHARGE = 2'd2,
`endif
    SEND      = 2'd1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [BYTE_W-1:0] sh_p [NBYTES];
  logic [BYTE_W-1:0] sh_n [NBYTES];
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     lane;
  logic              err_q;
  logic              capture;
  logic              xfer;
  logic              fault;

  // A lane is healthy only when its two rails are exact complements.
  always_comb begin
    fault = 1'b0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if ((sa_p[i*BYTE_W +: BYTE_W] ^ sa_n[i*BYTE_W +: BYTE_W]) != '1) fault = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (done) begin
          capture   = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready && cnt == LAST) begin
`ifdef AES_WDDL_UNLOAD_PRECHARGE_EN
          state_nxt = PRECHARGE;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef AES_WDDL_UNLOAD_PRECHARGE_EN
      PRECHARGE: begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign xfer     = out_valid & out_ready;
  assign lane     = LAST - cnt;
  assign out_last = out_valid && (cnt == LAST);
  assign out_data = sh_p[lane];
  assign err      = err_q;
`ifdef AES_WDDL_UNLOAD_PRECHARGE_EN
  assign out_data_n = sh_n[lane];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      err_q <= 1'b0;
      for (int unsigned i = 0; i < NBYTES; i++) begin
        sh_p[i] <= '0;
        sh_n[i] <= '0;
      end
    end else if (capture) begin
      cnt   <= '0;
      err_q <= fault;
      for (int unsigned i = 0; i < NBYTES; i++) begin
        sh_p[i] <= sa_p[i*BYTE_W +: BYTE_W];
        sh_n[i] <= sa_n[i*BYTE_W +: BYTE_W];
      end
    end else if (xfer) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
`ifdef AES_WDDL_UNLOAD_PRECHARGE_EN
      // Zero each lane as it leaves so the shadow's Hamming weight drains uniformly.
      sh_p[lane] <= '0;
      sh_n[lane] <= '0;
`endif
    end
`ifdef AES_WDDL_UNLOAD_PRECHARGE_EN
    else if (state == PRECHARGE) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        sh_p[i] <= '0;
        sh_n[i] <= '0;
      end
    end
`endif
  end

endmodule

// File: tb/tb_aes_wddl_unload.sv
// Directed self-checking bench for aes_wddl_unload; honours AES_WDDL_UNLOAD_PRECHARGE_EN when defined.
module tb_aes_wddl_unload;

  logic         clk = 1'b0;
  logic         rst;
  logic         done;
  logic [127:0] sa_p;
  logic [127:0] sa_n;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
`ifdef AES_WDDL_UNLOAD_PRECHARGE_EN
  logic [7:0]   out_data_n;
`endif
  logic         out_last;
  logic         busy;
  logic         err;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned fails  = 0;

  localparam logic [127:0] K     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KBAD  = ~K ^ (128'hff << 24);
  localparam logic [127:0] OTHER = 128'h00112233445566778899aabbccddeeff;

  logic [7:0] tab [16] = '{8'h69, 8'hc4, 8'he0, 8'hd8, 8'h6a, 8'h7b, 8'h04, 8'h30,
                           8'hd8, 8'hcd, 8'hb7, 8'h80, 8'h70, 8'hb4, 8'hc5, 8'h5a};

  aes_wddl_unload #(.NBYTES(16), .BYTE_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .done      (done),
    .sa_p      (sa_p),
    .sa_n      (sa_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef AES_WDDL_UNLOAD_PRECHARGE_EN
    .out_data_n(out_data_n),
`endif
    .out_last  (out_last),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done(input logic [127:0] p, input logic [127:0] n);
    sa_p = p;
    sa_n = n;
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  // Streams a full K block with ready held high.
  task automatic stream(input string tag, input logic exp_err);
    logic [7:0] xr;
    for (int i = 0; i < 16; i++) begin
      out_ready = 1'b1;
      xr = (exp_err && i == 12) ? 8'h00 : 8'hff;
      chk($sformatf("%s valid[%0d]", tag, i), out_valid, 1'b1);
      chk($sformatf("%s data[%0d]", tag, i), out_data, tab[i]);
      chk($sformatf("%s last[%0d]", tag, i), out_last, (i == 15));
      chk($sformatf("%s err[%0d]", tag, i), err, exp_err);
`ifdef AES_WDDL_UNLOAD_PRECHARGE_EN
      chk($sformatf("%s rails[%0d]", tag, i), out_data ^ out_data_n, xr);
`else
      chk($sformatf("%s xr[%0d]", tag, i), (out_data ^ xr) == (tab[i] ^ xr), 1'b1);
`endif
      step();
    end
  endtask

  task automatic end_block(input string tag);
    chk({tag, " end valid"}, out_valid, 1'b0);
    chk({tag, " end last"}, out_last, 1'b0);
`ifdef AES_WDDL_UNLOAD_PRECHARGE_EN
    chk({tag, " pre busy"}, busy, 1'b1);
    chk({tag, " pre data"}, out_data, 8'h00);
    chk({tag, " pre data_n"}, out_data_n, 8'h00);
    step();
`endif
    chk({tag, " end busy"}, busy, 1'b0);
  endtask

  initial begin
    int k;
    int cyc;
    rst = 1'b0; done = 1'b0; out_ready = 1'b0; sa_p = '0; sa_n = '0;
    step();
    step();
    chk("rst valid", out_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst err", err, 1'b0);
    chk("rst data", out_data, 8'h00);
    chk("rst last", out_last, 1'b0);
    rst = 1'b1;
    step();
    chk("idle valid", out_valid, 1'b0);

    // T1 streaming
    pulse_done(K, ~K);
    chk("T1 busy", busy, 1'b1);
    stream("T1", 1'b0);
    end_block("T1");

    // T2 backpressure 1,0,0,1,0,0...
    pulse_done(K, ~K);
    k = 0;
    cyc = 0;
    while (k < 16 && cyc < 100) begin
      out_ready = (cyc % 3 == 0);
      chk($sformatf("T2 valid c%0d", cyc), out_valid, 1'b1);
      chk($sformatf("T2 data c%0d", cyc), out_data, tab[k]);
      chk($sformatf("T2 last c%0d", cyc), out_last, (k == 15));
      step();
      if (out_ready) k++;
      cyc++;
    end
    chk("T2 transfers", k, 16);
    chk("T2 cycles", cyc, 46);
    out_ready = 1'b1;
    end_block("T2");

    // T3 rail fault on lane 3, then clean capture clears err
    pulse_done(K, KBAD);
    chk("T3 err", err, 1'b1);
    chk("T3 busy", busy, 1'b1);
    stream("T3", 1'b1);
    end_block("T3");
    chk("T3 sticky", err, 1'b1);
    pulse_done(K, ~K);
    chk("T3 clear", err, 1'b0);
    stream("T3b", 1'b0);
    end_block("T3b");

    // T4 done during streaming is ignored
    pulse_done(K, ~K);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        sa_p = OTHER;
        sa_n = OTHER;
        done = 1'b1;
      end
      chk($sformatf("T4 data[%0d]", i), out_data, tab[i]);
      chk($sformatf("T4 busy[%0d]", i), busy, 1'b1);
      chk($sformatf("T4 err[%0d]", i), err, 1'b0);
      step();
      done = 1'b0;
    end
    end_block("T4");
    chk("T4 err after", err, 1'b0);

    // T5 reset mid-block
    pulse_done(K, KBAD);
    chk("T5 err", err, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("T5 data[%0d]", i), out_data, tab[i]);
      step();
    end
    rst = 1'b0;
    step();
    chk("T5 valid", out_valid, 1'b0);
    chk("T5 busy", busy, 1'b0);
    chk("T5 err0", err, 1'b0);
    chk("T5 data0", out_data, 8'h00);
    rst = 1'b1;
    pulse_done(K, ~K);
    stream("T5", 1'b0);
    end_block("T5");

`ifdef AES_WDDL_UNLOAD_PRECHARGE_EN
    // T6 done during precharge ignored, next cycle accepted
    pulse_done(K, ~K);
    stream("T6", 1'b0);
    chk("T6 pre busy", busy, 1'b1);
    chk("T6 pre valid", out_valid, 1'b0);
    chk("T6 pre data_n", out_data_n, 8'h00);
    sa_p = K; sa_n = ~K; done = 1'b1;
    step();
    done = 1'b0;
    chk("T6 ignored busy", busy, 1'b0);
    chk("T6 ignored valid", out_valid, 1'b0);
    pulse_done(K, ~K);
    stream("T6b", 1'b0);
    end_block("T6b");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
